// File: rtl/adder_selftest_pkg.sv
// adder_selftest_pkg: shared FSM state, LED modes, corner-vector table and LFSR tap table
package adder_selftest_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_t;
  typedef enum logic [1:0] {LED_OFF, LED_ON, LED_BLINK} led_mode_t;
  typedef enum logic [1:0] {OP_ZERO, OP_ONE, OP_ONES} corner_op_t;
  localparam int CORNER_N = 3;
  localparam corner_op_t CORNER_A [CORNER_N] = '{OP_ZERO, OP_ONES, OP_ONES};
  localparam corner_op_t CORNER_B [CORNER_N] = '{OP_ZERO, OP_ONE, OP_ONES};
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      2:       return 64'h3;
      3:       return 64'h6;
      4:       return 64'hC;
      5:       return 64'h14;
      6:       return 64'h30;
      7:       return 64'h60;
      8:       return 64'hB8;
      16:      return 64'hB400;
      24:      return 64'hE10000;
      32:      return 64'h8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return (64'h1 << (w - 1)) | 64'h1;
    endcase
  endfunction
endpackage

// File: rtl/adder_selftest_led_blinker.sv
// adder_selftest_led_blinker: status LED driver; ports clk, reset, mode (off/on/blink), led
module adder_selftest_led_blinker
  import adder_selftest_pkg::*;
#(
  parameter int BLINK_DIV = 12000000,
  localparam int CNT_W = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1
) (
  input  logic      clk,
  input  logic      reset,
  input  led_mode_t mode,
  output logic      led
);
  logic [CNT_W-1:0] cnt;
  logic             phase;
  always_ff @(posedge clk) begin
    if (reset || mode != LED_BLINK) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
  assign led = mode == LED_ON || (mode == LED_BLINK && phase);
endmodule

// File: rtl/adder_selftest.sv
// adder_selftest: adder self-test harness; in clk/reset/start/dut_sum, out dut_a/dut_b/done/pass/err_count/first_fail_idx/led
module adder_selftest
  import adder_selftest_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          NUM_VECTORS = 256,
  parameter int          DUT_LATENCY = 0,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1,
  parameter int          BLINK_DIV   = 12000000,
  localparam int ERR_W = $clog2(NUM_VECTORS + 1),
  localparam int IDX_W = $clog2(NUM_VECTORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  input  logic [DATA_W-1:0] dut_sum,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic              led
);
  localparam int DR_W = DUT_LATENCY > 1 ? $clog2(DUT_LATENCY) : 1;
  localparam logic [DATA_W-1:0] SEED_LO = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] SEED_A = SEED_LO == '0 ? DATA_W'(1) : SEED_LO;
  localparam logic [DATA_W-1:0] SEED_B = ~SEED_LO == '0 ? DATA_W'(1) : ~SEED_LO;
  localparam logic [63:0] TAPS_ALL = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS = TAPS_ALL[DATA_W-1:0];
  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction
  function automatic logic [DATA_W-1:0] corner(input corner_op_t op);
    return op == OP_ZERO ? '0 : op == OP_ONE ? DATA_W'(1) : '1;
  endfunction
  state_t            state, result;
  led_mode_t         mode;
  logic [IDX_W-1:0]  idx, nidx, chk_i;
  logic [DATA_W-1:0] lfsr_a, lfsr_b, exp_now, chk_e;
  logic [ERR_W-1:0]  err_next;
  logic [DR_W-1:0]   drain_cnt;
  logic              chk_v, mismatch, idx_last, drain_last;
  assign exp_now = dut_a + dut_b;
  generate
    if (DUT_LATENCY == 0) begin : g_comb
      assign chk_v = state == RUN;
      assign chk_e = exp_now;
      assign chk_i = idx;
    end else begin : g_pipe
      // Expectation, index and valid travel alongside the DUT pipeline
      logic [DUT_LATENCY-1:0] v;
      logic [DATA_W-1:0]      e  [DUT_LATENCY];
      logic [IDX_W-1:0]       ix [DUT_LATENCY];
      always_ff @(posedge clk) begin
        v[0]  <= reset ? 1'b0 : state == RUN;
        e[0]  <= exp_now;
        ix[0] <= idx;
        for (int k = 1; k < DUT_LATENCY; k++) begin
          v[k]  <= reset ? 1'b0 : v[k-1];
          e[k]  <= e[k-1];
          ix[k] <= ix[k-1];
        end
      end
      assign chk_v = v[DUT_LATENCY-1];
      assign chk_e = e[DUT_LATENCY-1];
      assign chk_i = ix[DUT_LATENCY-1];
    end
  endgenerate
  assign mismatch   = chk_v && dut_sum != chk_e;
  assign err_next   = err_count + ERR_W'(mismatch);
  // The final comparison lands in the last RUN/DRAIN cycle, so the verdict uses err_next
  assign result     = err_next != '0 ? FAIL : PASS;
  assign nidx       = idx + IDX_W'(1);
  assign idx_last   = idx == IDX_W'(NUM_VECTORS - 1);
  assign drain_last = drain_cnt == DR_W'(DUT_LATENCY > 0 ? DUT_LATENCY - 1 : 0);
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      dut_a          <= '0;
      dut_b          <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      lfsr_a         <= SEED_A;
      lfsr_b         <= SEED_B;
      drain_cnt      <= '0;
    end else begin
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0) first_fail_idx <= chk_i;
      end
      case (state)
        RUN: begin
          if (idx_last) begin
            state     <= DUT_LATENCY == 0 ? result : DRAIN;
            drain_cnt <= '0;
          end else begin
            idx <= nidx;
            if (nidx < IDX_W'(CORNER_N)) begin
              dut_a <= corner(CORNER_A[nidx[1:0]]);
              dut_b <= corner(CORNER_B[nidx[1:0]]);
            end else begin
              dut_a  <= lfsr_a;
              dut_b  <= lfsr_b;
              lfsr_a <= step(lfsr_a);
              lfsr_b <= step(lfsr_b);
            end
          end
        end
        DRAIN: begin
          if (drain_last) state <= result;
          else drain_cnt <= drain_cnt + DR_W'(1);
        end
        default: begin
          if (start) begin
            state          <= RUN;
            idx            <= '0;
            dut_a          <= corner(CORNER_A[0]);
            dut_b          <= corner(CORNER_B[0]);
            err_count      <= '0;
            first_fail_idx <= '0;
            lfsr_a         <= SEED_A;
            lfsr_b         <= SEED_B;
          end
        end
      endcase
    end
  end
  assign done = state == PASS || state == FAIL;
  assign pass = state == PASS;
  assign mode = state == PASS ? LED_ON : state == FAIL ? LED_BLINK : LED_OFF;
  adder_selftest_led_blinker #(.BLINK_DIV(BLINK_DIV)) u_led (
    .clk  (clk),
    .reset(reset),
    .mode (mode),
    .led  (led)
  );
endmodule

// File: tb/tb_adder_selftest.sv
// tb_adder_selftest: self-checking bench for adder_selftest with behavioural adders and a reference model
module tb_adder_selftest;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [63:0] seq_ref [256];
  logic [63:0] seq_cur [256];
  logic        ua_start = 0, ua_corrupt = 0, ua_done, ua_pass, ua_led;
  logic [31:0] ua_a, ua_b, ua_sum;
  logic [8:0]  ua_err;
  logic [7:0]  ua_ffi;
  assign ua_sum = (ua_a + ua_b) ^ (ua_corrupt ? 32'h0000_0100 : 32'h0);
  adder_selftest #(.DUT_LATENCY(0), .BLINK_DIV(8)) u_a (
    .clk(clk), .reset(reset), .start(ua_start), .dut_a(ua_a), .dut_b(ua_b), .dut_sum(ua_sum),
    .done(ua_done), .pass(ua_pass), .err_count(ua_err), .first_fail_idx(ua_ffi), .led(ua_led));
  logic        ubc_start = 0, ub_done, ub_pass, ub_led, uc_done, uc_pass, uc_led;
  logic [31:0] ub_a, ub_b, uc_a, uc_b, pb0, pb1, pb2, pc0, pc1, pc2;
  logic [8:0]  ub_err, uc_err;
  logic [7:0]  ub_ffi, uc_ffi;
  always @(posedge clk) begin
    pb0 <= reset ? 32'h0 : ub_a + ub_b;
    pb1 <= reset ? 32'h0 : pb0;
    pb2 <= reset ? 32'h0 : pb1;
    pc0 <= reset ? 32'h0 : uc_a + uc_b;
    pc1 <= reset ? 32'h0 : pc0;
    pc2 <= reset ? 32'h0 : pc1;
  end
  adder_selftest #(.DUT_LATENCY(3), .BLINK_DIV(8)) u_b (
    .clk(clk), .reset(reset), .start(ubc_start), .dut_a(ub_a), .dut_b(ub_b), .dut_sum(pb2),
    .done(ub_done), .pass(ub_pass), .err_count(ub_err), .first_fail_idx(ub_ffi), .led(ub_led));
  adder_selftest #(.DUT_LATENCY(2), .BLINK_DIV(8)) u_c (
    .clk(clk), .reset(reset), .start(ubc_start), .dut_a(uc_a), .dut_b(uc_b), .dut_sum(pc2),
    .done(uc_done), .pass(uc_pass), .err_count(uc_err), .first_fail_idx(uc_ffi), .led(uc_led));
  logic        ud_start = 0, ud_done, ud_pass, ud_led;
  logic [31:0] ud_a, ud_b;
  logic [8:0]  ud_err;
  logic [7:0]  ud_ffi;
  adder_selftest #(.DUT_LATENCY(0), .BLINK_DIV(4)) u_d (
    .clk(clk), .reset(reset), .start(ud_start), .dut_a(ud_a), .dut_b(ud_b), .dut_sum(32'h0),
    .done(ud_done), .pass(ud_pass), .err_count(ud_err), .first_fail_idx(ud_ffi), .led(ud_led));

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    checks++; if ({ua_done, ua_pass, ua_led, ub_done, uc_done, ud_done, ud_led} !== 7'b0) begin failures++; $display("FAIL reset_flags: got %b want 0", {ua_done, ua_pass, ua_led, ub_done, uc_done, ud_done, ud_led}); end
    checks++; if ({ua_a, ua_b} !== 64'h0) begin failures++; $display("FAIL reset_operands: got %h want 0", {ua_a, ua_b}); end
    checks++; if ({ua_err, ua_ffi} !== 17'h0) begin failures++; $display("FAIL reset_counters: got err=%0d idx=%0d want 0", ua_err, ua_ffi); end
  endtask

  task automatic run_a(input int nfault, input bit noise, input string tag);
    bit flt [256];
    int exp_err = 0, exp_first = 0;
    bit early = 0;
    foreach (flt[k]) flt[k] = 0;
    for (int n = 0; n < nfault; n++) flt[$urandom_range(0, 255)] = 1;
    for (int k = 255; k >= 0; k--) if (flt[k]) begin exp_err++; exp_first = k; end
    @(negedge clk) ua_start = 1;
    @(posedge clk) #1 ua_start = 0;
    checks++; if (ua_err !== 9'd0) begin failures++; $display("FAIL %s err_at_start: got %0d want 0", tag, ua_err); end
    for (int k = 0; k < 256; k++) begin
      seq_cur[k] = {ua_a, ua_b};
      ua_corrupt = flt[k];
      early |= ua_done;
      ua_start = noise && $urandom_range(0, 3) == 0;
      @(posedge clk); #1;
    end
    ua_start = 0; ua_corrupt = 0;
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL %s early_done: got %b want 0", tag, early); end
    checks++; if (ua_done !== 1'b1) begin failures++; $display("FAIL %s done_at_256: got %b want 1", tag, ua_done); end
    checks++; if (ua_pass !== (exp_err == 0)) begin failures++; $display("FAIL %s pass: got %b want %b", tag, ua_pass, exp_err == 0); end
    checks++; if (ua_err !== 9'(exp_err)) begin failures++; $display("FAIL %s err_count: got %0d want %0d", tag, ua_err, exp_err); end
    checks++; if (ua_ffi !== 8'(exp_first)) begin failures++; $display("FAIL %s first_fail_idx: got %0d want %0d", tag, ua_ffi, exp_first); end
    checks++; if (ua_led !== 1'b1) begin failures++; $display("FAIL %s led_entry: got %b want 1", tag, ua_led); end
    checks++; if (seq_cur[0] !== 64'h0 || seq_cur[1] !== {32'hFFFF_FFFF, 32'h1} || seq_cur[2] !== {64{1'b1}})
      begin failures++; $display("FAIL %s corners: got %h %h %h", tag, seq_cur[0], seq_cur[1], seq_cur[2]); end
    checks++; if (seq_cur[3] !== {32'h0000_ACE1, 32'hFFFF_531E}) begin failures++; $display("FAIL %s first_lfsr: got %h want %h", tag, seq_cur[3], {32'h0000_ACE1, 32'hFFFF_531E}); end
  endtask

  task automatic test_latency();
    int tb_ = 0, tc = 0;
    @(negedge clk) ubc_start = 1;
    @(posedge clk) #1 ubc_start = 0;
    for (int t = 1; t <= 400; t++) begin
      @(posedge clk); #1;
      if (ub_done && tb_ == 0) tb_ = t;
      if (uc_done && tc == 0) tc = t;
    end
    checks++; if (tb_ != 259) begin failures++; $display("FAIL lat3_done_cycle: got %0d want 259", tb_); end
    checks++; if (ub_pass !== 1'b1 || ub_err !== 9'd0) begin failures++; $display("FAIL lat3_pass: got pass=%b err=%0d want 1/0", ub_pass, ub_err); end
    checks++; if (tc != 258) begin failures++; $display("FAIL lat2_done_cycle: got %0d want 258", tc); end
    checks++; if (uc_pass !== 1'b0 || uc_err == 9'd0) begin failures++; $display("FAIL lat2_misaligned: got pass=%b err=%0d want 0/>0", uc_pass, uc_err); end
    checks++; if (uc_ffi !== 8'd2) begin failures++; $display("FAIL lat2_first_fail: got %0d want 2", uc_ffi); end
  endtask

  task automatic test_forced_zero_blink();
    int exp_err = 0, exp_first = -1;
    @(negedge clk) ud_start = 1;
    @(posedge clk) #1 ud_start = 0;
    for (int k = 0; k < 256; k++) begin
      if (ud_a + ud_b != 32'h0) begin exp_err++; if (exp_first < 0) exp_first = k; end
      @(posedge clk); #1;
    end
    checks++; if (ud_done !== 1'b1 || ud_pass !== 1'b0) begin failures++; $display("FAIL zero_verdict: got done=%b pass=%b want 1/0", ud_done, ud_pass); end
    checks++; if (ud_ffi !== 8'd2 || exp_first != 2) begin failures++; $display("FAIL zero_first_fail: got %0d want 2 (model %0d)", ud_ffi, exp_first); end
    checks++; if (ud_err !== 9'(exp_err)) begin failures++; $display("FAIL zero_err_count: got %0d want %0d", ud_err, exp_err); end
    for (int t = 0; t < 16; t++) begin
      checks++; if (ud_led !== ((t / 4) % 2 == 0)) begin failures++; $display("FAIL blink_t%0d: got %b want %b", t, ud_led, (t / 4) % 2 == 0); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_faults();
    run_a(0, 0, "clean");
    seq_ref = seq_cur;
    run_a($urandom_range(1, 6), 0, "faulty");
  endtask

  task automatic test_back_to_back();
    bit same = 1;
    run_a(0, 1, "noise");
    foreach (seq_cur[k]) if (seq_cur[k] !== seq_ref[k]) same = 0;
    checks++; if (!same) begin failures++; $display("FAIL noise_sequence: got diverged want identical"); end
    run_a($urandom_range(1, 4), 0, "rerun");
  endtask

  task automatic test_reset_midrun();
    bit same = 1, idle = 1;
    @(negedge clk) ua_start = 1;
    @(posedge clk) #1 ua_start = 0;
    for (int k = 0; k < 100; k++) begin
      ua_corrupt = k == 5;
      @(posedge clk); #1;
    end
    ua_corrupt = 0;
    checks++; if (ua_err !== 9'd1) begin failures++; $display("FAIL midrun_partial_err: got %0d want 1", ua_err); end
    reset = 1;
    @(posedge clk); #1 reset = 0;
    checks++; if ({ua_done, ua_pass, ua_led} !== 3'b0) begin failures++; $display("FAIL abort_flags: got %b want 0", {ua_done, ua_pass, ua_led}); end
    checks++; if ({ua_err, ua_ffi} !== 17'h0 || {ua_a, ua_b} !== 64'h0) begin failures++; $display("FAIL abort_state: got err=%0d idx=%0d ops=%h want 0", ua_err, ua_ffi, {ua_a, ua_b}); end
    for (int t = 0; t < 300; t++) begin
      if (ua_done) idle = 0;
      @(posedge clk); #1;
    end
    checks++; if (!idle) begin failures++; $display("FAIL abort_stays_idle: got done want idle"); end
    run_a(0, 0, "fresh");
    foreach (seq_cur[k]) if (seq_cur[k] !== seq_ref[k]) same = 0;
    checks++; if (!same) begin failures++; $display("FAIL fresh_sequence: got diverged want identical"); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_forced_zero_blink();
    test_random_faults();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
